// File: rtl/rs_age_scheduler_if.sv
// Dispatch/issue handshake bundle for the ALU reservation-station age scheduler.
// master drives requests (dispatch/issue side); slave is the scheduler.
interface rs_age_scheduler_if #(
    parameter int RS    = 3,
    parameter int CNT_W = 15
);
    logic           dispatchValid;
    logic [RS:0]    selectReq;
    logic           execute;
    logic           clear;
    logic           validCommit;
    logic [RS:0]    writeRequests;
    logic [RS:0]    grants;
    logic           noSelect;
    logic           rsFull;
    logic [RS+1:0]  occupancy;
    logic [CNT_W:0] stallCycles;
    logic [CNT_W:0] issueCount;

    modport master (
        output dispatchValid, selectReq, execute, clear, validCommit,
        input  writeRequests, grants, noSelect, rsFull, occupancy, stallCycles, issueCount
    );

    modport slave (
        input  dispatchValid, selectReq, execute, clear, validCommit,
        output writeRequests, grants, noSelect, rsFull, occupancy, stallCycles, issueCount
    );
endinterface

// File: rtl/rs_age_scheduler.sv
// Allocation and oldest-first issue control for the 4-entry ALU reservation station.
// Optional stall/issue performance counters are built when RS_PERF_CNT_EN is defined.
module rs_age_scheduler #(
    parameter int RS    = 3,
    parameter int CNT_W = 15
) (
    input logic               clk,
    input logic               globalReset,
    rs_age_scheduler_if.slave bus
);
    localparam logic [RS:0]   ENTRY_ONE = {{RS{1'b0}}, 1'b1};
    localparam logic [RS+1:0] OCC_ZERO  = '0;

    logic [RS:0]       validVec;
    logic [RS:0][RS:0] age;
    logic [RS+1:0]     occupancy;
    logic              flush;
    logic              rsFull;
    logic              issueEn;
    logic [RS:0]       freeVec;
    logic [RS:0]       allocVec;
    logic [RS:0]       eligible;
    logic [RS:0]       grantVec;
    logic [RS+1:0]     occInc;
    logic [RS+1:0]     occDec;

    assign flush   = bus.clear & bus.validCommit;
    assign rsFull  = &validVec;
    assign freeVec = ~validVec;

    // Lowest free entry: isolate the least significant set bit of the free vector.
    assign allocVec = (bus.dispatchValid & ~rsFull & ~flush) ?
                      (freeVec & (~freeVec + ENTRY_ONE)) : '0;

    assign eligible = validVec & bus.selectReq;
    assign issueEn  = bus.execute & ~flush;

    // An entry wins only if no other eligible entry is older than it.
    always_comb begin
        grantVec = '0;
        for (int i = 0; i <= RS; i++) begin
            grantVec[i] = issueEn & eligible[i] & ~|(age[i] & eligible);
        end
    end

    assign occInc = {OCC_ZERO[RS+1:1], |allocVec};
    assign occDec = {OCC_ZERO[RS+1:1], |grantVec};

    always_ff @(posedge clk or posedge globalReset) begin
        if (globalReset) begin
            validVec  <= '0;
            age       <= '0;
            occupancy <= '0;
        end else if (flush) begin
            validVec  <= '0;
            age       <= '0;
            occupancy <= '0;
        end else begin
            validVec  <= (validVec & ~grantVec) | allocVec;
            occupancy <= occupancy + occInc - occDec;
            // New entry is younger than every survivor; freed or new columns drop out of other rows.
            for (int i = 0; i <= RS; i++) begin
                for (int j = 0; j <= RS; j++) begin
                    if (i == j) begin
                        age[i][j] <= 1'b0;
                    end else if (allocVec[i]) begin
                        age[i][j] <= validVec[j] & ~grantVec[j];
                    end else if (allocVec[j] | grantVec[j] | grantVec[i]) begin
                        age[i][j] <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.writeRequests = allocVec;
    assign bus.grants        = grantVec;
    assign bus.noSelect      = ~|grantVec;
    assign bus.rsFull        = rsFull;
    assign bus.occupancy     = occupancy;

`ifdef RS_PERF_CNT_EN
    logic [CNT_W:0] stallCnt;
    logic [CNT_W:0] issueCnt;

    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W:0] v);
        return (&v) ? v : v + {{CNT_W{1'b0}}, 1'b1};
    endfunction

    // Counters survive flushes; only the global reset clears them.
    always_ff @(posedge clk or posedge globalReset) begin
        if (globalReset) begin
            stallCnt <= '0;
            issueCnt <= '0;
        end else begin
            if (bus.dispatchValid & rsFull) stallCnt <= sat_inc(stallCnt);
            if (|grantVec)                  issueCnt <= sat_inc(issueCnt);
        end
    end

    assign bus.stallCycles = stallCnt;
    assign bus.issueCount  = issueCnt;
`else
    assign bus.stallCycles = '0;
    assign bus.issueCount  = '0;
`endif
endmodule

// File: tb/tb_rs_age_scheduler.sv
// Self-checking bench for rs_age_scheduler: vector table through a scoreboard queue,
// age-matrix invariant monitor, and hand-written counter / async-reset sequences.
module tb_rs_age_scheduler;
    localparam int RS    = 3;
    localparam int CNT_W = 15;
`ifdef RS_PERF_CNT_EN
    localparam int EXP_STALL = 5;
    localparam int EXP_ISSUE = 2;
`else
    localparam int EXP_STALL = 0;
    localparam int EXP_ISSUE = 0;
`endif

    typedef struct {
        bit         rst;
        bit         dv;
        logic [3:0] sel;
        bit         ex;
        bit         clr;
        bit         vc;
        logic [3:0] wr;
        logic [3:0] gr;
        bit         nos;
        bit         full;
        logic [2:0] occ;
    } vec_t;

    logic clk = 1'b0;
    logic globalReset;
    int   n_assert = 0;
    int   n_fail   = 0;
    vec_t tbl[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    rs_age_scheduler_if #(.RS(RS), .CNT_W(CNT_W)) bus ();

    rs_age_scheduler #(.RS(RS), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .globalReset (globalReset),
        .bus         (bus)
    );

    function automatic vec_t mk(int rst, int dv, int sel, int ex, int clr, int vc,
                                int wr, int gr, int nos, int full, int occ);
        vec_t t;
        t.rst  = rst[0];
        t.dv   = dv[0];
        t.sel  = sel[3:0];
        t.ex   = ex[0];
        t.clr  = clr[0];
        t.vc   = vc[0];
        t.wr   = wr[3:0];
        t.gr   = gr[3:0];
        t.nos  = nos[0];
        t.full = full[0];
        t.occ  = occ[2:0];
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int dv, input int sel, input int ex, input int clr, input int vc);
        bus.dispatchValid = dv[0];
        bus.selectReq     = sel[3:0];
        bus.execute       = ex[0];
        bus.clear         = clr[0];
        bus.validCommit   = vc[0];
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        globalReset = 1'b1;
        @(posedge clk);
        #1;
        globalReset = 1'b0;
    endtask

    task automatic check_out(input int k);
        vec_t e;
        if (exp_q.size() == 0) begin
            chk($sformatf("vec%0d scoreboard_empty", k), 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("vec%0d writeRequests", k), 32'(bus.writeRequests), 32'(e.wr));
            chk($sformatf("vec%0d grants", k),        32'(bus.grants),        32'(e.gr));
            chk($sformatf("vec%0d noSelect", k),      32'(bus.noSelect),      32'(e.nos));
            chk($sformatf("vec%0d rsFull", k),        32'(bus.rsFull),        32'(e.full));
            chk($sformatf("vec%0d occupancy", k),     32'(bus.occupancy),     32'(e.occ));
        end
    endtask

    // For every pair of valid entries exactly one must be older than the other.
    always @(negedge clk) begin
        if (globalReset === 1'b0) begin
            for (int i = 0; i <= RS; i++) begin
                for (int j = i + 1; j <= RS; j++) begin
                    if (dut.validVec[i] && dut.validVec[j]) begin
                        n_assert++;
                        if ((dut.age[i][j] ^ dut.age[j][i]) !== 1'b1) begin
                            n_fail++;
                            $display("FAIL age_invariant %0d/%0d: got %b%b required exactly one set",
                                     i, j, dut.age[i][j], dut.age[j][i]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        //                rst dv sel     ex clr vc wr      gr      nos full occ
        // Fill, then fifth dispatch blocked
        tbl.push_back(mk(1, 0, 'b0000, 0, 0, 0, 'b0000, 'b0000, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'b0000, 0, 0, 0, 'b0001, 'b0000, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'b0000, 0, 0, 0, 'b0010, 'b0000, 1, 0, 1));
        tbl.push_back(mk(0, 1, 'b0000, 0, 0, 0, 'b0100, 'b0000, 1, 0, 2));
        tbl.push_back(mk(0, 1, 'b0000, 0, 0, 0, 'b1000, 'b0000, 1, 0, 3));
        tbl.push_back(mk(0, 1, 'b0000, 0, 0, 0, 'b0000, 'b0000, 1, 1, 4));
        // Drain oldest first
        tbl.push_back(mk(0, 0, 'b1111, 1, 0, 0, 'b0000, 'b0001, 0, 1, 4));
        tbl.push_back(mk(0, 0, 'b1111, 1, 0, 0, 'b0000, 'b0010, 0, 0, 3));
        tbl.push_back(mk(0, 0, 'b1111, 1, 0, 0, 'b0000, 'b0100, 0, 0, 2));
        tbl.push_back(mk(0, 0, 'b1111, 1, 0, 0, 'b0000, 'b1000, 0, 0, 1));
        tbl.push_back(mk(0, 0, 'b1111, 1, 0, 0, 'b0000, 'b0000, 1, 0, 0));
        // Reused e0 is younger than e1; execute=0 holds
        tbl.push_back(mk(1, 1, 'b0000, 0, 0, 0, 'b0001, 'b0000, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'b0000, 0, 0, 0, 'b0010, 'b0000, 1, 0, 1));
        tbl.push_back(mk(0, 0, 'b0001, 1, 0, 0, 'b0000, 'b0001, 0, 0, 2));
        tbl.push_back(mk(0, 1, 'b0000, 0, 0, 0, 'b0001, 'b0000, 1, 0, 1));
        tbl.push_back(mk(0, 0, 'b0011, 0, 0, 0, 'b0000, 'b0000, 1, 0, 2));
        tbl.push_back(mk(0, 0, 'b0011, 1, 0, 0, 'b0000, 'b0010, 0, 0, 2));
        tbl.push_back(mk(0, 0, 'b0011, 1, 0, 0, 'b0000, 'b0001, 0, 0, 1));
        tbl.push_back(mk(0, 0, 'b0011, 1, 0, 0, 'b0000, 'b0000, 1, 0, 0));
        // Full: grant + dispatch same cycle, then concurrent allocate + grant
        tbl.push_back(mk(1, 1, 'b0000, 0, 0, 0, 'b0001, 'b0000, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'b0000, 0, 0, 0, 'b0010, 'b0000, 1, 0, 1));
        tbl.push_back(mk(0, 1, 'b0000, 0, 0, 0, 'b0100, 'b0000, 1, 0, 2));
        tbl.push_back(mk(0, 1, 'b0000, 0, 0, 0, 'b1000, 'b0000, 1, 0, 3));
        tbl.push_back(mk(0, 1, 'b0100, 1, 0, 0, 'b0000, 'b0100, 0, 1, 4));
        tbl.push_back(mk(0, 1, 'b0000, 0, 0, 0, 'b0100, 'b0000, 1, 0, 3));
        tbl.push_back(mk(0, 0, 'b0000, 0, 0, 0, 'b0000, 'b0000, 1, 1, 4));
        tbl.push_back(mk(0, 0, 'b0001, 1, 0, 0, 'b0000, 'b0001, 0, 1, 4));
        tbl.push_back(mk(0, 1, 'b1010, 1, 0, 0, 'b0001, 'b0010, 0, 0, 3));
        tbl.push_back(mk(0, 0, 'b1111, 1, 0, 0, 'b0000, 'b1000, 0, 0, 3));
        tbl.push_back(mk(0, 0, 'b1111, 1, 0, 0, 'b0000, 'b0100, 0, 0, 2));
        tbl.push_back(mk(0, 0, 'b1111, 1, 0, 0, 'b0000, 'b0001, 0, 0, 1));
        tbl.push_back(mk(0, 0, 'b1111, 1, 0, 0, 'b0000, 'b0000, 1, 0, 0));
        // clear without validCommit is not a flush; then real flush
        tbl.push_back(mk(1, 1, 'b0000, 0, 0, 0, 'b0001, 'b0000, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'b0000, 0, 0, 0, 'b0010, 'b0000, 1, 0, 1));
        tbl.push_back(mk(0, 1, 'b0000, 0, 0, 0, 'b0100, 'b0000, 1, 0, 2));
        tbl.push_back(mk(0, 1, 'b0111, 1, 1, 0, 'b1000, 'b0001, 0, 0, 3));
        tbl.push_back(mk(0, 1, 'b1111, 1, 1, 1, 'b0000, 'b0000, 1, 0, 3));
        tbl.push_back(mk(0, 1, 'b0000, 0, 0, 0, 'b0001, 'b0000, 1, 0, 0));
        tbl.push_back(mk(0, 0, 'b1111, 1, 0, 0, 'b0000, 'b0001, 0, 0, 1));
        tbl.push_back(mk(0, 0, 'b0000, 0, 0, 0, 'b0000, 'b0000, 1, 0, 0));

        drive(0, 0, 0, 0, 0);
        globalReset = 1'b1;
        @(posedge clk);
        #1;
        globalReset = 1'b0;

        for (int k = 0; k < tbl.size(); k++) begin
            if (tbl[k].rst) do_reset();
            drive(int'(tbl[k].dv), int'(tbl[k].sel), int'(tbl[k].ex),
                  int'(tbl[k].clr), int'(tbl[k].vc));
            exp_q.push_back(tbl[k]);
            @(negedge clk);
            check_out(k);
            @(posedge clk);
            #1;
        end

        // Performance counters: 5 stalled dispatch cycles, 2 grants, flush keeps them
        do_reset();
        repeat (4) begin
            drive(1, 0, 0, 0, 0);
            @(posedge clk);
            #1;
        end
        repeat (5) begin
            drive(1, 0, 0, 0, 0);
            @(posedge clk);
            #1;
        end
        repeat (2) begin
            drive(0, 'b1111, 1, 0, 0);
            @(posedge clk);
            #1;
        end
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("perf stallCycles", 32'(bus.stallCycles), 32'(EXP_STALL));
        chk("perf issueCount",  32'(bus.issueCount),  32'(EXP_ISSUE));
        chk("perf occupancy",   32'(bus.occupancy),   32'd2);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 1, 1);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("flush stallCycles", 32'(bus.stallCycles), 32'(EXP_STALL));
        chk("flush issueCount",  32'(bus.issueCount),  32'(EXP_ISSUE));
        chk("flush occupancy",   32'(bus.occupancy),   32'd0);

        // Asynchronous reset between clock edges
        @(posedge clk);
        #1;
        drive(1, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        drive(0, 'b1111, 1, 0, 0);
        #2;
        globalReset = 1'b1;
        #1;
        chk("async occupancy",   32'(bus.occupancy),   32'd0);
        chk("async grants",      32'(bus.grants),      32'd0);
        chk("async noSelect",    32'(bus.noSelect),    32'd1);
        chk("async rsFull",      32'(bus.rsFull),      32'd0);
        chk("async stallCycles", 32'(bus.stallCycles), 32'd0);
        chk("async issueCount",  32'(bus.issueCount),  32'd0);
        drive(0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        globalReset = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
